// File: rtl/adsr_pkg.sv
// Shared definitions for the ADSR envelope generator: phase codes, the
// state width and the helpers that derive the level ceiling and the
// decay/release shift.
package adsr_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsrState_t;

  // Largest representable envelope level for a given width.
  function automatic int unsigned waveMax(input int unsigned depth);
    return (32'd1 << depth) - 32'd1;
  endfunction

  // Shift applied to the level to size a decay/release step. Shifting by
  // the full level width always yields zero, which floors the step to 1
  // and gives the linear curve.
  function automatic int unsigned stepShift(input bit expEnable,
                                            input int unsigned expShift,
                                            input int unsigned depth);
    return expEnable ? expShift : depth;
  endfunction

endpackage

// File: rtl/adsr_rate_step.sv
// Phase-rate accumulator for the ADSR envelope. Each sample tick adds the
// rate into a wrapping accumulator; a carry out of the MSB is one level
// step. A rate of zero steps on every tick so the phase completes at once.
module adsr_rate_step
  import adsr_pkg::*;
#(
  parameter int RATE_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SampleTick,
  input  logic                  Clear,
  input  logic [RATE_WIDTH-1:0] Rate,
  output logic                  Step
);

  logic [RATE_WIDTH-1:0] acc;
  logic [RATE_WIDTH:0]   sum;

  // Widened add so the carry out of the accumulator is visible.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, Rate};
    Step = SampleTick && ((Rate == '0) || sum[RATE_WIDTH]);
  end

  // Accumulator: cleared on phase changes, otherwise advances on ticks.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc <= '0;
    end else if (Clear) begin
      acc <= '0;
    end else if (SampleTick) begin
      acc <= sum[RATE_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator. Gate edges steer the phase FSM; the level moves
// only on sample ticks, paced by the per-phase rate accumulator.
// Optional feature: define ADSR_EXP_EN for exponential decay/release steps
// of max(1, Envelope >> EXP_SHIFT); otherwise every step is 1.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int WAVE_DEPTH = 8,
  parameter int RATE_WIDTH = 8,
  parameter int EXP_SHIFT  = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   SampleTick,
  input  logic                   Gate,
  input  logic [RATE_WIDTH-1:0]  AttackRate,
  input  logic [RATE_WIDTH-1:0]  DecayRate,
  input  logic [WAVE_DEPTH-1:0]  SustainLevel,
  input  logic [RATE_WIDTH-1:0]  ReleaseRate,
  output logic [WAVE_DEPTH-1:0]  Envelope,
  output logic [STATE_WIDTH-1:0] State,
  output logic                   Active,
  output logic                   Done
);

`ifdef ADSR_EXP_EN
  localparam bit ExpEnabled = 1'b1;
`else
  localparam bit ExpEnabled = 1'b0;
`endif

  localparam logic [WAVE_DEPTH-1:0] WaveMax = WAVE_DEPTH'(waveMax(WAVE_DEPTH));
  localparam int unsigned StepShift = stepShift(ExpEnabled, EXP_SHIFT, WAVE_DEPTH);

  adsrState_t            state, stateNext;
  logic [WAVE_DEPTH-1:0] envReg, envNext;
  logic                  doneReg, doneNext;
  logic                  gateDly1, gateDly2;
  logic                  gateRise, gateFall;
  logic                  stateValid;
  logic                  clearAcc;
  logic                  step;
  logic                  rateIsZero;
  logic [RATE_WIDTH-1:0] rateSel;
  logic [WAVE_DEPTH-1:0] shifted, stepSize;
  logic [WAVE_DEPTH-1:0] attackPost, decayPost, releasePost;

  // Pick the rate that paces the current phase.
  always_comb begin
    rateSel = '0;
    case (state)
      ATTACK:  rateSel = AttackRate;
      DECAY:   rateSel = DecayRate;
      RELEASE: rateSel = ReleaseRate;
      default: rateSel = '0;
    endcase
    rateIsZero = (rateSel == '0);
  end

  adsr_rate_step #(
    .RATE_WIDTH(RATE_WIDTH)
  ) uRateStep (
    .Clock      (Clock),
    .Reset      (Reset),
    .SampleTick (SampleTick),
    .Clear      (clearAcc),
    .Rate       (rateSel),
    .Step       (step)
  );

  // Gate edges compare the registered gate with its previous value, so a
  // change shows up in State two rising edges after the input moves.
  always_comb begin
    gateRise = gateDly1 & ~gateDly2;
    gateFall = ~gateDly1 & gateDly2;
  end

  // Candidate levels for each phase assuming this tick is taken.
  always_comb begin
    shifted  = envReg >> StepShift;
    stepSize = (shifted == '0) ? WAVE_DEPTH'(1) : shifted;

    attackPost = envReg;
    if (step) begin
      attackPost = (rateIsZero || (envReg == WaveMax)) ? WaveMax : envReg + 1'b1;
    end

    decayPost = envReg;
    if (step) begin
      if (!rateIsZero && (envReg > SustainLevel) && ((envReg - SustainLevel) > stepSize)) begin
        decayPost = envReg - stepSize;
      end else begin
        decayPost = SustainLevel;
      end
    end

    releasePost = envReg;
    if (step) begin
      releasePost = (!rateIsZero && (envReg > stepSize)) ? envReg - stepSize : '0;
    end
  end

  // Phase FSM: invalid codes recover first, then gate edges, then the tick step.
  always_comb begin
    stateNext  = state;
    envNext    = envReg;
    doneNext   = 1'b0;
    clearAcc   = 1'b0;
    stateValid = (state == IDLE) || (state == ATTACK) || (state == DECAY) ||
                 (state == SUSTAIN) || (state == RELEASE);

    if (!stateValid) begin
      stateNext = IDLE;
      clearAcc  = 1'b1;
    end else if (gateRise) begin
      stateNext = ATTACK;
      clearAcc  = 1'b1;
    end else if (gateFall && ((state == ATTACK) || (state == DECAY) || (state == SUSTAIN))) begin
      stateNext = RELEASE;
      clearAcc  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          envNext  = '0;
          clearAcc = 1'b1;
        end
        ATTACK: begin
          if (SampleTick) begin
            envNext = attackPost;
            if (attackPost == WaveMax) begin
              stateNext = DECAY;
              clearAcc  = 1'b1;
            end
          end
        end
        DECAY: begin
          if (SampleTick) begin
            envNext = decayPost;
            if (decayPost <= SustainLevel) begin
              stateNext = SUSTAIN;
              clearAcc  = 1'b1;
            end
          end
        end
        SUSTAIN: begin
          clearAcc = 1'b1;
          if (SampleTick) begin
            envNext = SustainLevel;
          end
        end
        RELEASE: begin
          if (SampleTick) begin
            envNext = releasePost;
            if (releasePost == '0) begin
              stateNext = IDLE;
              doneNext  = 1'b1;
              clearAcc  = 1'b1;
            end
          end
        end
        default: begin
          stateNext = IDLE;
          clearAcc  = 1'b1;
        end
      endcase
    end
  end

  // State, level, done pulse and gate history registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      envReg   <= '0;
      doneReg  <= 1'b0;
      gateDly1 <= 1'b0;
      gateDly2 <= 1'b0;
    end else begin
      state    <= stateNext;
      envReg   <= envNext;
      doneReg  <= doneNext;
      gateDly1 <= Gate;
      gateDly2 <= gateDly1;
    end
  end

  // Registered outputs straight from the state and level registers.
  always_comb begin
    Envelope = envReg;
    State    = state;
    Active   = (state != IDLE);
    Done     = doneReg;
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope at WAVE_DEPTH=8, RATE_WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adsr_envelope;

  logic       clock = 1'b0;
  logic       resetN;
  logic       sampleTick;
  logic       gate;
  logic [7:0] attackRate, decayRate, sustainLevel, releaseRate;
  logic [7:0] envelope;
  logic [2:0] state;
  logic       active, done;

  int checkCount = 0;
  int passCount  = 0;

  adsr_envelope #(
    .WAVE_DEPTH(8),
    .RATE_WIDTH(8),
    .EXP_SHIFT (3)
  ) dut (
    .Clock        (clock),
    .Reset        (resetN),
    .SampleTick   (sampleTick),
    .Gate         (gate),
    .AttackRate   (attackRate),
    .DecayRate    (decayRate),
    .SustainLevel (sustainLevel),
    .ReleaseRate  (releaseRate),
    .Envelope     (envelope),
    .State        (state),
    .Active       (active),
    .Done         (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] aRate, input logic [7:0] dRate,
                               input logic [7:0] sLevel, input logic [7:0] rRate);
    attackRate   = aRate;
    decayRate    = dRate;
    sustainLevel = sLevel;
    releaseRate  = rRate;
  endtask

  task automatic resetDut();
    gate       = 1'b0;
    sampleTick = 1'b1;
    resetN     = 1'b0;
    cycles(2);
    resetN = 1'b1;
    cycles(1);
  endtask

  function automatic int stepAmt(input int level);
`ifdef ADSR_EXP_EN
    return ((level >> 3) == 0) ? 1 : (level >> 3);
`else
    return 1 + (level & 0);
`endif
  endfunction

  int doneCount;
  int expected;

  initial begin
    applyStimulus(8'd255, 8'd0, 8'd64, 8'd255);
    resetDut();
    checkOutput("resetEnv", envelope, 0);
    checkOutput("resetState", state, 0);
    checkOutput("resetActive", active, 0);
    checkOutput("resetDone", done, 0);

    // Async reset mid-attack, then gate latency of two edges.
    gate = 1'b1;
    cycles(2);
    checkOutput("attackEntry", state, 1);
    cycles(101);
    checkOutput("attackAt100", envelope, 100);
    resetN = 1'b0;
    gate   = 1'b0;
    #1;
    checkOutput("asyncRstEnv", envelope, 0);
    checkOutput("asyncRstState", state, 0);
    cycles(1);
    resetN = 1'b1;
    cycles(1);
    gate = 1'b1;
    cycles(1);
    checkOutput("gateLat1", state, 0);
    cycles(1);
    checkOutput("gateLat2", state, 1);

    // Slow attack: one step every two ticks, 510 ticks to the top.
    applyStimulus(8'd128, 8'd0, 8'd200, 8'd255);
    resetDut();
    gate = 1'b1;
    cycles(2);
    cycles(1);
    checkOutput("slowTick1", envelope, 0);
    cycles(1);
    checkOutput("slowTick2", envelope, 1);
    cycles(507);
    checkOutput("slowTick509", envelope, 254);
    checkOutput("slowState509", state, 1);
    cycles(1);
    checkOutput("slowTop", envelope, 255);
    checkOutput("slowDecay", state, 2);
    cycles(1);
    checkOutput("instDecayEnv", envelope, 200);
    checkOutput("instDecayState", state, 3);

    // Instant attack and decay, live sustain tracking, then release.
    applyStimulus(8'd0, 8'd0, 8'd64, 8'd255);
    resetDut();
    gate = 1'b1;
    cycles(2);
    checkOutput("instEntryEnv", envelope, 0);
    cycles(1);
    checkOutput("instAttack", envelope, 255);
    checkOutput("instAttackSt", state, 2);
    cycles(1);
    checkOutput("instSustain", envelope, 64);
    checkOutput("instSustainSt", state, 3);
    sustainLevel = 8'd80;
    cycles(1);
    checkOutput("sustainTrack", envelope, 80);
    sustainLevel = 8'd64;
    cycles(1);
    checkOutput("sustainBack", envelope, 64);
    gate = 1'b0;
    cycles(2);
    checkOutput("releaseEntry", state, 4);
    checkOutput("releaseEntryEnv", envelope, 64);
    doneCount = 0;
    for (int i = 1; i <= 66; i++) begin
      cycles(1);
      if (done) doneCount++;
      if (i == 64) begin
        checkOutput("releaseAt1", envelope, 1);
        checkOutput("releaseSt1", state, 4);
      end
      if (i == 65) begin
        checkOutput("releaseZero", envelope, 0);
        checkOutput("releaseIdle", state, 0);
        checkOutput("releaseDone", done, 1);
      end
    end
    checkOutput("donePulses", doneCount, 1);
    checkOutput("idleActive", active, 0);

    // Legato retrigger from the release phase.
    applyStimulus(8'd0, 8'd0, 8'd64, 8'd255);
    resetDut();
    gate = 1'b1;
    cycles(4);
    attackRate = 8'd255;
    gate = 1'b0;
    cycles(2);
    doneCount = 0;
    for (int i = 0; i < 34; i++) begin
      cycles(1);
      if (done) doneCount++;
    end
    checkOutput("legatoAt31", envelope, 31);
    gate = 1'b1;
    cycles(1);
    checkOutput("legatoAt30", envelope, 30);
    checkOutput("legatoStillRel", state, 4);
    cycles(1);
    checkOutput("legatoAttack", state, 1);
    checkOutput("legatoKeep", envelope, 30);
    cycles(1);
    checkOutput("legatoFirst", envelope, 30);
    cycles(1);
    checkOutput("legatoUp", envelope, 31);
    if (done) doneCount++;
    checkOutput("legatoNoDone", doneCount, 0);

    // Sparse sample ticks: level only moves on tick cycles.
    applyStimulus(8'd255, 8'd0, 8'd64, 8'd255);
    resetDut();
    sampleTick = 1'b0;
    gate = 1'b1;
    cycles(2);
    checkOutput("sparseEntry", state, 1);
    for (int t = 1; t <= 4; t++) begin
      sampleTick = 1'b1;
      cycles(1);
      sampleTick = 1'b0;
      checkOutput("sparseTick", envelope, t - 1);
      cycles(3);
      checkOutput("sparseHold", envelope, t - 1);
    end

    // Release curve from full scale (exponential when the feature is built in).
    applyStimulus(8'd0, 8'd0, 8'd255, 8'd255);
    resetDut();
    gate = 1'b1;
    cycles(4);
    checkOutput("fullSustain", state, 3);
    gate = 1'b0;
    cycles(2);
    checkOutput("curveEntry", state, 4);
    cycles(1);
    checkOutput("curveTick1", envelope, 255);
    expected = 255;
    for (int k = 0; k < 300 && expected != 0; k++) begin
      expected = (expected > stepAmt(expected)) ? expected - stepAmt(expected) : 0;
      cycles(1);
      checkOutput("curveStep", envelope, expected);
    end
    checkOutput("curveIdle", state, 0);
    checkOutput("curveDone", done, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Parametrised ADSR envelope generator; the next generation of the existing single-mode envelope block.
- Implements all four phases, gate-driven, with per-phase rate inputs and a sustain level input.
- Advances only on a sample-rate strobe.
- Output feeds the voice amplitude multiplier after the oscillator.

Parameters:
WAVE_DEPTH, 8, envelope/sustain width in bits; WAVE_MAX = 2^WAVE_DEPTH-1
RATE_WIDTH, 8, width of the rate inputs and of the phase accumulator
EXP_SHIFT, 3, right-shift used for the exponential step (only with ADSR_EXP_EN)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset (asserted when 0)
SampleTick  in  1  one-cycle strobe; envelope level changes only when high
Gate  in  1  note on (1) / note off (0)
AttackRate  in  RATE_WIDTH  accumulator increment in ATTACK; 0 = instant
DecayRate  in  RATE_WIDTH  increment in DECAY; 0 = instant
SustainLevel  in  WAVE_DEPTH  hold level
ReleaseRate  in  RATE_WIDTH  increment in RELEASE; 0 = instant
Envelope  out  WAVE_DEPTH  current level, registered
State  out  3  current phase code
Active  out  1  State != IDLE
Done  out  1  one-cycle pulse when RELEASE reaches 0

Behaviour:
- Reset asserted (async):
  - Envelope=0, State=IDLE, accumulator=0, registered gate=0, Done=0.
  - Reset mid-note abandons the note immediately.
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5-7 recover to IDLE on the next clock.
- Gate edges:
  - Detected every Clock against a registered copy, independent of SampleTick.
  - Rising edge: State=ATTACK next cycle, accumulator cleared, Envelope kept (legato retrigger, no jump to 0).
  - Falling edge in ATTACK/DECAY/SUSTAIN: State=RELEASE, accumulator cleared, Envelope kept.
  - Edges take priority over the tick step in the same cycle.
- Step engine:
  - On SampleTick, acc = acc + rate (RATE_WIDTH bits).
  - Carry out of the MSB produces one step; the sum wraps.
  - Rate 0 jumps straight to the phase target on the first tick.
- ATTACK:
  - Envelope +1 per step.
  - At WAVE_MAX go to DECAY, accumulator cleared; no overshoot.
- DECAY:
  - Envelope -1 per step, clamped at SustainLevel.
  - Go to SUSTAIN on the tick where Envelope <= SustainLevel after the step.
  - SustainLevel = WAVE_MAX: DECAY lasts one tick.
- SUSTAIN:
  - Envelope = SustainLevel on every tick, tracking live changes.
  - Stays until Gate falls.
- RELEASE:
  - Envelope -1 per step, clamped at 0.
  - Reaching 0 gives State=IDLE and Done=1 for one cycle.
  - Already 0 on entry: IDLE and Done on the first tick.
- IDLE: Envelope held at 0.
- Gate rising in RELEASE: re-enters ATTACK from the current level; no Done pulse.
- Latency:
  - Gate to State change: 1 clock after Gate is sampled (2 rising edges from the Gate change).
  - Tick to Envelope change: 1 clock.

Optional Feature:
- Macro: ADSR_EXP_EN.
- Defined: each DECAY/RELEASE step subtracts max(1, Envelope >> EXP_SHIFT), same clamps, giving an exponential curve. ATTACK stays linear.
- Undefined: linear step of 1 in all phases; EXP_SHIFT unused.

Decomposition:
- Package adsr_pkg:
  - State codes (IDLE..RELEASE) and state width constant 3.
  - WAVE_MAX derivation function.
- Sub-module adsr_rate_step:
  - Accumulator plus carry detect.
  - Inputs: Clock, Reset, SampleTick, Clear, Rate.
  - Output: Step pulse; asserted for rate 0 on any tick.
- Top holds the FSM, gate edge detector and level arithmetic.

Test Plan (WAVE_DEPTH=8, RATE_WIDTH=8, SampleTick every cycle unless stated):
- Reset low mid-ATTACK at Envelope=100 -> Envelope=0, State=0 with no clock edge; Reset high then Gate high -> State=1 after 2 edges.
- AttackRate=128, Gate high -> Envelope +1 every 2 ticks, reaches 255 after 510 ticks, State=2 on the same clock.
- AttackRate=0, DecayRate=0, SustainLevel=64 -> Envelope=255 on tick 1, 64 on tick 2, State=3; change SustainLevel to 80 -> Envelope=80 on next tick.
- Gate low in SUSTAIN at 64, ReleaseRate=255 -> -1 per carry, reaches 0, State=0, Done high exactly 1 cycle.
- Gate low then high again at Envelope=30 in RELEASE -> State=1 next clock, Envelope continues from 30 upward, no Done.
- SampleTick every 4th cycle, AttackRate=255 -> Envelope changes only on tick cycles; ADSR_EXP_EN defined, release from 255 with EXP_SHIFT=3 -> steps 255, 224, 196, ... with final steps of 1 down to 0.
